// File: rtl/io_responder.sv
// io_responder
//   I/O execution unit for the CPU control FSM. When the FSM enters its Io
//   state (one-hot bit 6), the unit starts exactly one device transaction. It
//   runs a req/ack handshake on the device bus and returns a one-cycle io_done
//   pulse. Input ops also return read data and a register-file write strobe.
//   If the device never acknowledges, the unit aborts after TIMEOUT cycles and
//   flags io_err. TIMEOUT = 0 disables the abort.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   state[8:0]            one-hot FSM state, bit 6 = Io
//   io_dir                0 = input (device->CPU), 1 = output (CPU->device)
//   io_addr, io_wdata     port address / write data from the decoded instruction
//   dev_req, dev_we       device request, device write enable (latched io_dir)
//   dev_addr, dev_wdata   latched address / write data, stable during a request
//   dev_ack, dev_rdata    one-cycle device acknowledge, read data valid with ack
//   io_done, io_err       completion pulse, timeout flag (held until next done)
//   rd_data, rd_we        captured read data, one-cycle register write strobe
module io_responder #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        state,
  input  logic              io_dir,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              dev_req,
  output logic              dev_we,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [DATA_W-1:0] dev_wdata,
  input  logic              dev_ack,
  input  logic [DATA_W-1:0] dev_rdata,
  output logic              io_done,
  output logic              io_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_we
);

  // Keep the counter at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } fsm_t;

  fsm_t             fsm;
  logic             state_io_q;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic             terminal;

  // Only the Io bit of the one-hot state matters here.
  logic unused_state;
  assign unused_state = ^{state[8:7], state[5:0]};

  // Rising edge of the Io bit. This allows one transaction per Io visit, even
  // when the FSM stays in Io after io_done.
  assign start = state[6] & ~state_io_q;

  assign terminal = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      state_io_q <= 1'b0;
      cnt        <= '0;
      dev_req    <= 1'b0;
      dev_we     <= 1'b0;
      dev_addr   <= '0;
      dev_wdata  <= '0;
      io_done    <= 1'b0;
      io_err     <= 1'b0;
      rd_data    <= '0;
      rd_we      <= 1'b0;
    end else begin
      state_io_q <= state[6];
      io_done    <= 1'b0;
      rd_we      <= 1'b0;

      case (fsm)
        IDLE: begin
          if (start) begin
            dev_we    <= io_dir;
            dev_addr  <= io_addr;
            dev_wdata <= io_wdata;
            dev_req   <= 1'b1;
            cnt       <= '0;
            fsm       <= REQ;
          end
        end

        REQ: begin
          if (!state[6]) begin
            // The FSM has left Io, so drop the request without reporting completion.
            dev_req <= 1'b0;
            fsm     <= IDLE;
          end else if (dev_ack) begin
            // An ack in the terminal-count cycle takes priority over the timeout.
            dev_req <= 1'b0;
            if (!dev_we) begin
              rd_data <= dev_rdata;
            end
            io_err  <= 1'b0;
            io_done <= 1'b1;
            rd_we   <= ~dev_we;
            fsm     <= DONE;
          end else if (terminal) begin
            dev_req <= 1'b0;
            if (!dev_we) begin
              rd_data <= '1;
            end
            io_err  <= 1'b1;
            io_done <= 1'b1;
            rd_we   <= ~dev_we;
            fsm     <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          fsm <= IDLE;
        end

        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 4;

  localparam logic [8:0] ST_IO     = 9'b0_0100_0000;
  localparam logic [8:0] ST_INCPC  = 9'b0_1000_0000;
  localparam logic [8:0] ST_FETCH  = 9'b0_0000_0001;
  localparam logic [8:0] ST_DECODE = 9'b0_0000_0010;

  logic              clk = 1'b0;
  logic              rst;
  logic [8:0]        state;
  logic              io_dir;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              dev_req;
  logic              dev_we;
  logic [ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic              dev_ack;
  logic [DATA_W-1:0] dev_rdata;
  logic              io_done;
  logic              io_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_we;

  int checks = 0;
  int errors = 0;

  // The model keeps the values the unit must hold between transactions.
  logic [DATA_W-1:0] exp_rd;
  logic              exp_err;

  always #5 clk = ~clk;

  io_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .state(state), .io_dir(io_dir), .io_addr(io_addr),
    .io_wdata(io_wdata), .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata),
    .io_done(io_done), .io_err(io_err), .rd_data(rd_data), .rd_we(rd_we)
  );

  // The model predicts a single Io visit. The FSM enters Io at edge k=0.
  // The device acks d cycles after dev_req rises. The FSM stays in Io for
  // "hold" extra cycles after the done cycle.
  // The request lasts N = min(d+1, TIMEOUT) cycles, in cycles 1..N.
  // The done pulse is in cycle N+1.
  task automatic run_txn(input logic dir, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                         input int d, input int hold);
    int n;
    bit timed_out;
    logic exp_req, exp_done, exp_rwe;
    timed_out = (d + 1 > TIMEOUT);
    n = timed_out ? TIMEOUT : d + 1;
    for (int k = 0; k <= n + 2 + hold; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        state    = ST_IO;
        io_dir   = dir;
        io_addr  = addr;
        io_wdata = wdata;
      end else begin
        // Scramble the instruction fields after the start edge so the bench can check latching.
        io_dir   = 1'($urandom);
        io_addr  = ADDR_W'($urandom);
        io_wdata = DATA_W'($urandom);
      end
      if (k == n + 2 + hold) state = ST_INCPC;
      dev_ack   = (k == d + 1);
      dev_rdata = (k == d + 1) ? rdata : DATA_W'($urandom);
      @(negedge clk);
      exp_req  = (k >= 1 && k <= n);
      exp_done = (k == n + 1);
      exp_rwe  = exp_done && !dir;
      if (exp_done) begin
        exp_err = timed_out;
        if (!dir) exp_rd = timed_out ? '1 : rdata;
      end
      checks++;
      if (dev_req !== exp_req) begin
        $display("FAIL dev_req k=%0d d=%0d: got %b want %b", k, d, dev_req, exp_req);
        errors++;
      end
      checks++;
      if (io_done !== exp_done) begin
        $display("FAIL io_done k=%0d d=%0d: got %b want %b", k, d, io_done, exp_done);
        errors++;
      end
      checks++;
      if (rd_we !== exp_rwe) begin
        $display("FAIL rd_we k=%0d d=%0d: got %b want %b", k, d, rd_we, exp_rwe);
        errors++;
      end
      if (exp_req) begin
        checks++;
        if ({dev_we, dev_addr, dev_wdata} !== {dir, addr, wdata}) begin
          $display("FAIL dev_bus k=%0d: got we=%b a=%h w=%h want we=%b a=%h w=%h",
                   k, dev_we, dev_addr, dev_wdata, dir, addr, wdata);
          errors++;
        end
      end
      if (k > n) begin
        checks++;
        if (io_err !== exp_err || rd_data !== exp_rd) begin
          $display("FAIL result k=%0d d=%0d: got err=%b rd=%h want err=%b rd=%h",
                   k, d, io_err, rd_data, exp_err, exp_rd);
          errors++;
        end
      end
    end
    dev_ack = 1'b0;
  endtask

  // The FSM steps through non-Io states between visits. This lets the Io bit fall.
  task automatic leave_io();
    @(posedge clk); #1 state = ST_FETCH;
    @(posedge clk); #1 state = ST_DECODE;
  endtask

  task automatic test_reset();
    state = '0; io_dir = 0; io_addr = '0; io_wdata = '0; dev_ack = 0; dev_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp_rd = '0; exp_err = 1'b0;
    checks++;
    if ({dev_req, dev_we, dev_addr, dev_wdata, io_done, io_err, rd_data, rd_we} !== '0) begin
      $display("FAIL reset: got req=%b we=%b a=%h w=%h done=%b err=%b rd=%h rwe=%b want all 0",
               dev_req, dev_we, dev_addr, dev_wdata, io_done, io_err, rd_data, rd_we);
      errors++;
    end
  endtask

  task automatic test_output_op();
    run_txn(1'b1, 4'h3, 8'hA5, 8'h00, 2, 0);
    leave_io();
  endtask

  task automatic test_input_op();
    run_txn(1'b0, 4'h9, 8'h00, 8'h5C, 0, 0);
    leave_io();
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 4'h1, 8'h00, 8'h33, 7, 0);
    leave_io();
    // An ack in the terminal-count cycle completes the op without an error.
    run_txn(1'b0, 4'h2, 8'h00, 8'hC3, TIMEOUT - 1, 0);
    leave_io();
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 4'h7, 8'h11, 8'h00, 1, 0);
    leave_io();
    run_txn(1'b0, 4'h8, 8'h00, 8'h9E, 0, 5);
    leave_io();
  endtask

  task automatic test_abort();
    @(posedge clk); #1 state = ST_IO; io_dir = 1'b0;
    repeat (2) @(posedge clk);
    #1 state = ST_INCPC;
    dev_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (dev_req !== 1'b0 || io_done !== 1'b0 || rd_we !== 1'b0 || rd_data !== exp_rd) begin
          $display("FAIL abort k=%0d: got req=%b done=%b rwe=%b rd=%h want 0 0 0 %h",
                   k, dev_req, io_done, rd_we, rd_data, exp_rd);
          errors++;
        end
      end
    end
    leave_io();
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1 state = ST_IO; io_dir = 1'b1; io_addr = 4'h5; io_wdata = 8'h77;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (dev_req !== 1'b1) begin
      $display("FAIL mid_reset_pre: got dev_req=%b want 1", dev_req);
      errors++;
    end
    rst = 1'b1; state = '0;
    #1;
    exp_rd = '0; exp_err = 1'b0;
    checks++;
    if ({dev_req, dev_we, dev_addr, dev_wdata, io_done} !== '0) begin
      $display("FAIL mid_reset_async: got req=%b we=%b a=%h w=%h done=%b want 0",
               dev_req, dev_we, dev_addr, dev_wdata, io_done);
      errors++;
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (io_done !== 1'b0 || dev_req !== 1'b0) begin
        $display("FAIL mid_reset_quiet k=%0d: got done=%b req=%b want 0 0", k, io_done, dev_req);
        errors++;
      end
    end
    run_txn(1'b0, 4'hB, 8'h00, 8'h42, 1, 0);
    leave_io();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
      leave_io();
    end
  endtask

  initial begin
    test_reset();
    test_output_op();
    test_input_op();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test before the time limit, want the test to finish");
    $fatal(1, "watchdog");
  end

endmodule
